// File: rtl/nn_layer_pkg.sv
// Shared types and helpers for neuron_layer_engine: FSM state enum, saturating add
// and the accumulator width check.
package nn_layer_pkg;

   localparam int unsigned DefInW  = 8;
   localparam int unsigned DefWW   = 8;
   localparam int unsigned DefAccW = 18;

   // Wide enough for any practical ACC_W; callers pass their real width to sat_add.
   localparam int unsigned SatW = 64;

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StDrain,
      StOutput
   } nn_state_e;

   typedef struct packed {
      logic            sat;
      logic [SatW-1:0] sum;
   } sat_res_t;

   function automatic logic acc_width_ok(input int unsigned acc_w, input int unsigned in_w,
                                         input int unsigned w_w);
      return acc_w >= in_w + w_w;
   endfunction

   localparam bit DefAccWidthOk = acc_width_ok(DefAccW, DefInW, DefWW);

   // Adds two sign-extended operands and clamps the sum to a signed w-bit range.
   function automatic sat_res_t sat_add(input logic signed [SatW-1:0] a,
                                        input logic signed [SatW-1:0] b,
                                        input int unsigned w);
      logic signed [SatW-1:0] sum;
      logic signed [SatW-1:0] lim;
      logic signed [SatW-1:0] hi;
      logic signed [SatW-1:0] lo;
      sat_res_t res;
      sum = a + b;
      lim = 1;
      lim = lim <<< (w - 1);
      hi  = lim - 1;
      lo  = -lim;
      res.sat = 1'b0;
      res.sum = sum;
      if (sum > hi) begin
         res.sum = hi;
         res.sat = 1'b1;
      end else if (sum < lo) begin
         res.sum = lo;
         res.sat = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/neuron_mac.sv
// One neuron: signed multiply, saturating accumulate onto a loaded bias, sticky
// saturation flag. acc_next_o exposes the value the accumulator takes at the next edge.
module neuron_mac
   import nn_layer_pkg::*;
#(
   parameter int unsigned IN_W  = DefInW,
   parameter int unsigned W_W   = DefWW,
   parameter int unsigned ACC_W = DefAccW
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic [ACC_W-1:0] bias_i,
   input  logic             mac_en_i,
   input  logic [IN_W-1:0]  act_i,
   input  logic [W_W-1:0]   weight_i,
   output logic [ACC_W-1:0] acc_next_o,
   output logic             sat_o
);

   localparam int unsigned ProdW = IN_W + W_W;

   logic [ACC_W-1:0]        acc_q, acc_d;
   logic                    sat_q, sat_d;
   logic signed [ProdW-1:0] act_ext, wt_ext, prod;
   sat_res_t                sum;
   logic                    unused_sum_hi;

   always_comb begin
      act_ext = ProdW'($signed(act_i));
      wt_ext  = ProdW'($signed(weight_i));
      prod    = act_ext * wt_ext;
      sum     = sat_add(SatW'($signed(acc_q)), SatW'(prod), ACC_W);
      acc_d   = acc_q;
      sat_d   = sat_q;
      if (load_i) begin
         acc_d = bias_i;
         sat_d = 1'b0;
      end else if (mac_en_i) begin
         acc_d = sum.sum[ACC_W-1:0];
         sat_d = sat_q | sum.sat;
      end
   end

   // Upper bits merely repeat the clamped sign.
   assign unused_sum_hi = ^sum.sum[SatW-1:ACC_W];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         acc_q <= '0;
         sat_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         sat_q <= sat_d;
      end
   end

   assign acc_next_o = acc_d;
   assign sat_o      = sat_q;

endmodule

// File: rtl/neuron_layer_engine.sv
// Start/done-controlled layer of N_NEURONS parallel saturating MAC neurons.
// Build option: define NEURON_RELU_EN to apply ReLU when results enter the output register.
module neuron_layer_engine
   import nn_layer_pkg::*;
#(
   parameter int unsigned N_NEURONS = 28,
   parameter int unsigned N_INPUTS  = 784,
   parameter int unsigned IN_W      = DefInW,
   parameter int unsigned W_W       = DefWW,
   parameter int unsigned ACC_W     = DefAccW
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [N_NEURONS*ACC_W-1:0]   bias_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [IN_W-1:0]              in_data,
   output logic [$clog2(N_INPUTS)-1:0]  wt_addr,
   input  logic [N_NEURONS*W_W-1:0]     wt_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [N_NEURONS*ACC_W-1:0]   out_data,
   output logic [N_NEURONS-1:0]         sat_flag,
   output logic                         busy
);

   localparam int unsigned AddrW = $clog2(N_INPUTS);

   if (!acc_width_ok(ACC_W, IN_W, W_W)) begin : gen_acc_w_check
      $error("neuron_layer_engine: ACC_W must be at least IN_W + W_W");
   end

   nn_state_e                state_q, state_d;
   logic [AddrW-1:0]         k_q, k_d;
   logic [IN_W-1:0]          in_reg_q;
   logic                     stage_vld_q;
   logic [N_NEURONS*ACC_W-1:0] out_q, out_d;
   logic                     start_acc, in_fire, last_in;

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      start_acc = 1'b0;
      in_fire   = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      wt_addr   = '0;
      last_in   = (k_q == AddrW'(N_INPUTS - 1));
      unique case (state_q)
         StIdle: begin
            busy = 1'b0;
            if (start) begin
               start_acc = 1'b1;
               k_d       = '0;
               state_d   = StAccum;
            end
         end
         StAccum: begin
            in_ready = 1'b1;
            wt_addr  = k_q;
            if (in_valid) begin
               in_fire = 1'b1;
               if (last_in) begin
                  state_d = StDrain;
               end else begin
                  k_d = k_q + AddrW'(1);
               end
            end
         end
         StDrain: begin
            state_d = StOutput;
         end
         StOutput: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         k_q         <= '0;
         in_reg_q    <= '0;
         stage_vld_q <= 1'b0;
         out_q       <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         stage_vld_q <= in_fire;
         if (in_fire) begin
            in_reg_q <= in_data;
         end
         // Capture the accumulators including the final product landing this cycle.
         if (state_q == StDrain) begin
            out_q <= out_d;
         end
      end
   end

   for (genvar i = 0; i < N_NEURONS; i++) begin : gen_neuron
      logic [ACC_W-1:0] acc_nxt;

      neuron_mac #(
         .IN_W  (IN_W),
         .W_W   (W_W),
         .ACC_W (ACC_W)
      ) u_mac (
         .clk_i      (clk),
         .reset_i    (reset),
         .load_i     (start_acc),
         .bias_i     (bias_data[i*ACC_W +: ACC_W]),
         .mac_en_i   (stage_vld_q),
         .act_i      (in_reg_q),
         .weight_i   (wt_data[i*W_W +: W_W]),
         .acc_next_o (acc_nxt),
         .sat_o      (sat_flag[i])
      );

`ifdef NEURON_RELU_EN
      assign out_d[i*ACC_W +: ACC_W] = acc_nxt[ACC_W-1] ? '0 : acc_nxt;
`else
      assign out_d[i*ACC_W +: ACC_W] = acc_nxt;
`endif
   end

   assign out_data = out_q;

endmodule

// File: tb/tb_neuron_layer_engine.sv
// Directed self-checking bench for neuron_layer_engine: a 2x4 instance for function and
// handshake scenarios, a 2x32 instance for saturation.
module tb_neuron_layer_engine;

   localparam int unsigned NN = 2;
   localparam int unsigned NA = 4;
   localparam int unsigned NB = 32;
   localparam int unsigned IW = 8;
   localparam int unsigned WW = 8;
   localparam int unsigned AW = 18;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nvec = 0;
   int nerr = 0;

   logic              a_start, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
   logic [NN*AW-1:0]  a_bias, a_out_data;
   logic [IW-1:0]     a_in_data;
   logic [1:0]        a_wt_addr;
   logic [NN*WW-1:0]  a_wt_data;
   logic [NN-1:0]     a_sat;
   logic [NN*WW-1:0]  a_wt_mem [NA];

   logic              b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
   logic [NN*AW-1:0]  b_bias, b_out_data;
   logic [IW-1:0]     b_in_data;
   logic [4:0]        b_wt_addr;
   logic [NN*WW-1:0]  b_wt_data;
   logic [NN-1:0]     b_sat;
   logic [NN*WW-1:0]  b_wt_mem [NB];

   always @(posedge clk) a_wt_data <= a_wt_mem[a_wt_addr];
   always @(posedge clk) b_wt_data <= b_wt_mem[b_wt_addr];

   neuron_layer_engine #(
      .N_NEURONS (NN), .N_INPUTS (NA), .IN_W (IW), .W_W (WW), .ACC_W (AW)
   ) dut_a (
      .clk (clk), .reset (reset), .start (a_start), .bias_data (a_bias),
      .in_valid (a_in_valid), .in_ready (a_in_ready), .in_data (a_in_data),
      .wt_addr (a_wt_addr), .wt_data (a_wt_data), .out_valid (a_out_valid),
      .out_ready (a_out_ready), .out_data (a_out_data), .sat_flag (a_sat), .busy (a_busy)
   );

   neuron_layer_engine #(
      .N_NEURONS (NN), .N_INPUTS (NB), .IN_W (IW), .W_W (WW), .ACC_W (AW)
   ) dut_b (
      .clk (clk), .reset (reset), .start (b_start), .bias_data (b_bias),
      .in_valid (b_in_valid), .in_ready (b_in_ready), .in_data (b_in_data),
      .wt_addr (b_wt_addr), .wt_data (b_wt_data), .out_valid (b_out_valid),
      .out_ready (b_out_ready), .out_data (b_out_data), .sat_flag (b_sat), .busy (b_busy)
   );

   function automatic logic [NN*AW-1:0] pack2(input int e0, input int e1);
      return {AW'(e1), AW'(e0)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_begin(input int b0, input int b1);
      a_bias  = {AW'(b1), AW'(b0)};
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
   endtask

   // hs_cyc is the cycle whose closing edge takes the handshake.
   task automatic a_send(input int v, output int hs_cyc, output logic [1:0] addr, output bit ok);
      ok = 1'b0;
      hs_cyc = 0;
      addr = '0;
      a_in_data  = IW'(v);
      a_in_valid = 1'b1;
      for (int c = 0; c < 20 && !ok; c++) begin
         if (a_in_ready) begin
            ok = 1'b1;
            hs_cyc = cyc;
            addr = a_wt_addr;
         end
         tick();
      end
      a_in_valid = 1'b0;
   endtask

   task automatic a_wait_out(output int v_cyc, output bit ok);
      for (int c = 0; c < 20 && !a_out_valid; c++) tick();
      ok = a_out_valid;
      v_cyc = cyc;
   endtask

   task automatic a_release();
      a_out_ready = 1'b1;
      tick();
      a_out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      a_start = 1'b1;
      tick();
      nvec++; if (a_busy !== 1'b0) begin nerr++; $display("FAIL reset_start_same_cycle: busy %0b want 0", a_busy); end
      a_start = 1'b0;
      tick();
      nvec++; if ({a_in_ready, a_out_valid, a_busy} !== 3'b000) begin nerr++; $display("FAIL reset_ctrl: ready/valid/busy %b want 000", {a_in_ready, a_out_valid, a_busy}); end
      nvec++; if (a_out_data !== '0) begin nerr++; $display("FAIL reset_out_data: got %h want 0", a_out_data); end
      nvec++; if ({a_sat, a_wt_addr} !== 4'b0) begin nerr++; $display("FAIL reset_sat_addr: got %b want 0000", {a_sat, a_wt_addr}); end
      nvec++; if ({b_busy, b_out_valid, b_out_data} !== '0) begin nerr++; $display("FAIL reset_b: got %h want 0", {b_busy, b_out_valid, b_out_data}); end
      reset = 1'b0;
      // Inputs offered while idle must not be taken.
      a_in_valid = 1'b1;
      a_in_data  = 8'd9;
      for (int c = 0; c < 2; c++) begin
         tick();
         nvec++; if ({a_in_ready, a_busy} !== 2'b00) begin nerr++; $display("FAIL idle_in_valid: ready/busy %b want 00", {a_in_ready, a_busy}); end
      end
      a_in_valid = 1'b0;
   endtask

   task automatic test_basic();
      int hs, v; logic [1:0] addr; bit ok;
      for (int i = 0; i < int'(NA); i++) a_wt_mem[i] = {8'd2, 8'd1};
      a_begin(0, 0);
      nvec++; if ({a_in_ready, a_busy} !== 2'b11) begin nerr++; $display("FAIL basic_start: ready/busy %b want 11", {a_in_ready, a_busy}); end
      for (int i = 0; i < int'(NA); i++) begin
         a_send(i + 1, hs, addr, ok);
         nvec++; if ({ok, addr} !== {1'b1, 2'(i)}) begin nerr++; $display("FAIL basic_addr%0d: ok/addr %b want %b", i, {ok, addr}, {1'b1, 2'(i)}); end
      end
      a_wait_out(v, ok);
      nvec++; if (!ok || v - hs != 2) begin nerr++; $display("FAIL basic_latency: %0d cycles (seen %0b) want 2", v - hs, ok); end
      nvec++; if (a_out_data !== pack2(10, 20)) begin nerr++; $display("FAIL basic_data: got %h want %h", a_out_data, pack2(10, 20)); end
      nvec++; if (a_sat !== 2'b00) begin nerr++; $display("FAIL basic_sat: got %b want 00", a_sat); end
      a_release();
      nvec++; if ({a_out_valid, a_busy} !== 2'b00) begin nerr++; $display("FAIL basic_done: valid/busy %b want 00", {a_out_valid, a_busy}); end
   endtask

   task automatic test_row_weights();
      int hs, v; logic [1:0] addr; bit ok;
      for (int i = 0; i < int'(NA); i++) a_wt_mem[i] = {8'(-(i + 1)), 8'(i + 1)};
      a_begin(0, 0);
      for (int i = 0; i < int'(NA); i++) a_send(i + 1, hs, addr, ok);
      a_wait_out(v, ok);
      nvec++; if (!ok || a_out_data !== pack2(30, -30)) begin nerr++; $display("FAIL row_weights_data: got %h want %h", a_out_data, pack2(30, -30)); end
      a_release();
   endtask

   task automatic test_bubbles();
      int hs, v; logic [1:0] addr; bit ok;
      for (int i = 0; i < int'(NA); i++) a_wt_mem[i] = {8'd2, 8'd1};
      a_out_ready = 1'b1;
      a_begin(0, 0);
      for (int i = 0; i < int'(NA); i++) begin
         if (i > 0) begin
            for (int g = 0; g < 3; g++) begin
               nvec++; if ({a_in_ready, a_wt_addr} !== {1'b1, 2'(i)}) begin nerr++; $display("FAIL bubble_hold%0d_%0d: ready/addr %b want %b", i, g, {a_in_ready, a_wt_addr}, {1'b1, 2'(i)}); end
               tick();
            end
         end
         a_send(i + 1, hs, addr, ok);
      end
      a_wait_out(v, ok);
      nvec++; if (!ok || v - hs != 2) begin nerr++; $display("FAIL bubble_latency: %0d cycles (seen %0b) want 2", v - hs, ok); end
      nvec++; if (a_out_data !== pack2(10, 20)) begin nerr++; $display("FAIL bubble_data: got %h want %h", a_out_data, pack2(10, 20)); end
      tick();
      nvec++; if ({a_out_valid, a_busy} !== 2'b00) begin nerr++; $display("FAIL bubble_done: valid/busy %b want 00", {a_out_valid, a_busy}); end
      a_out_ready = 1'b0;
   endtask

   task automatic test_negative();
      int hs, v; logic [1:0] addr; bit ok;
      logic [NN*AW-1:0] exp;
`ifdef NEURON_RELU_EN
      exp = pack2(0, 0);
`else
      exp = pack2(-100, -100);
`endif
      a_begin(-100, -100);
      for (int i = 0; i < int'(NA); i++) a_send(0, hs, addr, ok);
      a_wait_out(v, ok);
      nvec++; if (!ok || a_out_data !== exp) begin nerr++; $display("FAIL negative_data: got %h want %h", a_out_data, exp); end
      nvec++; if (a_sat !== 2'b00) begin nerr++; $display("FAIL negative_sat: got %b want 00", a_sat); end
      a_release();
   endtask

   task automatic test_reset_mid_pass();
      int hs, v; logic [1:0] addr; bit ok;
      a_begin(0, 0);
      a_send(1, hs, addr, ok);
      a_send(2, hs, addr, ok);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      nvec++; if ({a_busy, a_in_ready, a_out_valid} !== 3'b000) begin nerr++; $display("FAIL midreset_ctrl: busy/ready/valid %b want 000", {a_busy, a_in_ready, a_out_valid}); end
      nvec++; if (a_wt_addr !== 2'd0) begin nerr++; $display("FAIL midreset_addr: got %0d want 0", a_wt_addr); end
      tick();
      a_begin(5, 5);
      for (int i = 0; i < int'(NA); i++) a_send(i + 1, hs, addr, ok);
      a_wait_out(v, ok);
      nvec++; if (!ok || a_out_data !== pack2(15, 25)) begin nerr++; $display("FAIL midreset_data: got %h want %h", a_out_data, pack2(15, 25)); end
      a_release();
   endtask

   task automatic test_back_to_back();
      int hs, v; logic [1:0] addr; bit ok;
      a_begin(0, 0);
      for (int i = 0; i < int'(NA); i++) a_send(i + 1, hs, addr, ok);
      a_wait_out(v, ok);
      for (int c = 0; c < 5; c++) begin
         nvec++; if (!a_out_valid || a_out_data !== pack2(10, 20)) begin nerr++; $display("FAIL backpressure_hold%0d: valid %0b data %h want 1 %h", c, a_out_valid, a_out_data, pack2(10, 20)); end
         nvec++; if (a_in_ready !== 1'b0 || a_sat !== 2'b00) begin nerr++; $display("FAIL backpressure_ctrl%0d: ready %0b sat %b want 0 00", c, a_in_ready, a_sat); end
         a_start = (c == 2);
         a_bias  = pack2(7, 7);
         tick();
      end
      a_start = 1'b0;
      a_release();
      a_begin(0, 0);
      nvec++; if ({a_in_ready, a_busy, a_out_valid} !== 3'b110) begin nerr++; $display("FAIL restart_after_hs: ready/busy/valid %b want 110", {a_in_ready, a_busy, a_out_valid}); end
      for (int i = 0; i < int'(NA); i++) a_send(1, hs, addr, ok);
      a_wait_out(v, ok);
      nvec++; if (!ok || a_out_data !== pack2(4, 8)) begin nerr++; $display("FAIL restart_data: got %h want %h", a_out_data, pack2(4, 8)); end
      a_release();
   endtask

   task automatic test_saturation();
      int n, first, last;
      for (int i = 0; i < int'(NB); i++) b_wt_mem[i] = {8'd127, 8'd127};
      b_bias  = '0;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      b_in_data  = 8'd127;
      b_in_valid = 1'b1;
      n = 0; first = 0; last = 0;
      for (int c = 0; c < 200 && n < int'(NB); c++) begin
         if (b_in_ready) begin
            if (n == 0) first = cyc;
            last = cyc;
            n++;
         end
         tick();
      end
      b_in_valid = 1'b0;
      nvec++; if (n != int'(NB) || last - first != int'(NB) - 1) begin nerr++; $display("FAIL sat_throughput: %0d accepts over %0d cycles want %0d over %0d", n, last - first + 1, NB, NB); end
      for (int c = 0; c < 20 && !b_out_valid; c++) tick();
      // First-accept cycle through out_valid cycle inclusive.
      nvec++; if (!b_out_valid || cyc - first + 1 != int'(NB) + 2) begin nerr++; $display("FAIL sat_latency: %0d cycles (valid %0b) want %0d", cyc - first + 1, b_out_valid, NB + 2); end
      nvec++; if (b_out_data !== pack2(131071, 131071)) begin nerr++; $display("FAIL sat_data: got %h want %h", b_out_data, pack2(131071, 131071)); end
      nvec++; if (b_sat !== 2'b11) begin nerr++; $display("FAIL sat_flag: got %b want 11", b_sat); end
      b_out_ready = 1'b1;
      tick();
      b_out_ready = 1'b0;
      nvec++; if ({b_busy, b_sat} !== 3'b011) begin nerr++; $display("FAIL sat_done: busy/sat %b want 011", {b_busy, b_sat}); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, want finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      a_start = 1'b0; a_bias = '0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
      b_start = 1'b0; b_bias = '0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
      for (int i = 0; i < int'(NA); i++) a_wt_mem[i] = '0;
      for (int i = 0; i < int'(NB); i++) b_wt_mem[i] = '0;
      #1;
      test_reset();
      test_basic();
      test_row_weights();
      test_bubbles();
      test_negative();
      test_reset_mid_pass();
      test_back_to_back();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
